rmii_frame_capture: RTL and testbench

- Parametrised RMII receive sniffer on the PHY reference clock (50 MHz, LAN8720).
- Finds preamble/SFD, assembles dibits into bytes and stores the first C_bytes bytes of each frame in a register buffer.
- Reports frame length, frame count and a valid flag.
- The flattened buffer output feeds hex_decoder_v for on-screen inspection.
- Adds over the dibit-only sniffer: SFD alignment, byte assembly, length/count reporting, and a one-shot hold mode with rearm.

---
 rtl/rmii_frame_capture.sv | 127 ++++++++++++
 tb/tb_rmii_frame_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rmii_frame_capture.sv
// RMII receive sniffer: aligns on preamble/SFD, assembles LSB-first dibits into
// bytes and keeps the first C_bytes bytes of each frame plus length/count status.
module rmii_frame_capture #(
    parameter int unsigned C_bytes     = 64,
    parameter int unsigned C_sfd_align = 1,
    parameter int unsigned C_hold      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   crs_dv,
    input  logic [1:0]             rxd,
    input  logic                   rearm,
    output logic [8*C_bytes-1:0]   data,
    output logic [15:0]            frame_len,
    output logic [15:0]            frame_count,
    output logic                   valid,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        HOLD
    } state_t;

    state_t      state;
    logic [15:0] byte_cnt;
    logic [1:0]  dibit_cnt;
    logic [5:0]  shift;
    logic        seen_01;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            data        <= '0;
            frame_len   <= '0;
            frame_count <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            byte_cnt    <= '0;
            dibit_cnt   <= '0;
            shift       <= '0;
            seen_01     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (crs_dv) begin
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        if (C_sfd_align != 0) begin
                            state   <= PREAMBLE;
                            seen_01 <= 1'b0;
                        end else begin
                            // raw mode: this very dibit is d0 of byte 0
                            state       <= DATA;
                            shift[1:0]  <= rxd;
                            dibit_cnt   <= 2'd1;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!crs_dv) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rxd == 2'b11 && seen_01) begin
                        state     <= DATA;
                        byte_cnt  <= '0;
                        dibit_cnt <= '0;
                    end else if (rxd == 2'b01) begin
                        seen_01 <= 1'b1;
                    end
                end

                DATA: begin
                    if (crs_dv) begin
                        dibit_cnt <= dibit_cnt + 2'd1;
                        case (dibit_cnt)
                            2'd0: shift[1:0] <= rxd;
                            2'd1: shift[3:2] <= rxd;
                            2'd2: shift[5:4] <= rxd;
                            default: begin
                                for (int unsigned k = 0; k < C_bytes; k++) begin
                                    if (byte_cnt == 16'(k))
                                        data[8*k +: 8] <= {rxd, shift};
                                end
                                // saturates so frame_len tops out at 65535
                                if (byte_cnt != 16'hFFFF)
                                    byte_cnt <= byte_cnt + 16'd1;
                            end
                        endcase
                    end else begin
                        frame_len   <= byte_cnt;
                        frame_count <= frame_count + 16'd1;
                        valid       <= 1'b1;
                        busy        <= 1'b0;
                        dibit_cnt   <= '0;
                        if (C_hold != 0)
                            state <= HOLD;
                        else
                            state <= IDLE;
                    end
                end

                HOLD: begin
                    if (rearm) begin
                        valid <= 1'b0;
                        if (crs_dv) begin
                            state   <= PREAMBLE;
                            busy    <= 1'b1;
                            seen_01 <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_frame_capture.sv
// Directed bench for rmii_frame_capture: continuous, one-shot hold and raw instances.
module tb_rmii_frame_capture;

    logic         clk = 1'b0;
    logic         reset;
    logic         crs_dv;
    logic [1:0]   rxd;
    logic         rearm;

    logic [511:0] c_data;
    logic [15:0]  c_len, c_cnt;
    logic         c_valid, c_busy;
    logic [63:0]  h_data;
    logic [15:0]  h_len, h_cnt;
    logic         h_valid, h_busy;
    logic [31:0]  r_data;
    logic [15:0]  r_len, r_cnt;
    logic         r_valid, r_busy;

    int vectors = 0;
    int errors  = 0;
    logic [511:0] exp_buf;

    always #10 clk = ~clk;

    rmii_frame_capture #(.C_bytes(64), .C_sfd_align(1), .C_hold(0)) u_cont (
        .clk(clk), .reset(reset), .crs_dv(crs_dv), .rxd(rxd), .rearm(rearm),
        .data(c_data), .frame_len(c_len), .frame_count(c_cnt),
        .valid(c_valid), .busy(c_busy)
    );

    rmii_frame_capture #(.C_bytes(8), .C_sfd_align(1), .C_hold(1)) u_hold (
        .clk(clk), .reset(reset), .crs_dv(crs_dv), .rxd(rxd), .rearm(rearm),
        .data(h_data), .frame_len(h_len), .frame_count(h_cnt),
        .valid(h_valid), .busy(h_busy)
    );

    rmii_frame_capture #(.C_bytes(4), .C_sfd_align(0), .C_hold(0)) u_raw (
        .clk(clk), .reset(reset), .crs_dv(crs_dv), .rxd(rxd), .rearm(rearm),
        .data(r_data), .frame_len(r_len), .frame_count(r_cnt),
        .valid(r_valid), .busy(r_busy)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_dibit(input logic [1:0] d);
        @(negedge clk);
        crs_dv = 1'b1;
        rxd    = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_dibit(b[1:0]);
        send_dibit(b[3:2]);
        send_dibit(b[5:4]);
        send_dibit(b[7:6]);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    // Drop crs_dv; returns at the following negedge, after the edge that saw the drop.
    task automatic end_frame();
        @(negedge clk);
        crs_dv = 1'b0;
        rxd    = 2'b00;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        crs_dv = 1'b0;
        rxd    = 2'b00;
        rearm  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        crs_dv = 1'b0;
        rxd    = 2'b00;
        rearm  = 1'b0;
        do_reset();

        check("reset_data",  c_data, '0);
        check("reset_len",   c_len, 0);
        check("reset_count", c_cnt, 0);
        check("reset_valid", c_valid, 0);
        check("reset_busy",  c_busy, 0);

        // Basic frame
        send_preamble();
        send_byte(8'h01);
        check("busy_in_data", c_busy, 1);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        end_frame();
        check("basic_data",  c_data[31:0], 32'h04030201);
        check("basic_len",   c_len, 4);
        check("basic_count", c_cnt, 1);
        check("basic_valid", c_valid, 1);
        check("basic_busy",  c_busy, 0);

        // Overflow: 100 bytes into a 64-byte buffer
        send_preamble();
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        end_frame();
        for (int k = 0; k < 64; k++) exp_buf[8*k +: 8] = 8'(k);
        check("ovf_data",    c_data, exp_buf);
        check("ovf_byte63",  c_data[511:504], 8'h3F);
        check("ovf_len",     c_len, 100);
        check("ovf_count",   c_cnt, 2);

        // Aborted preamble: no SFD, nothing counted
        for (int i = 0; i < 3; i++) send_byte(8'h55);
        end_frame();
        check("abort_count", c_cnt, 2);
        check("abort_data",  c_data, exp_buf);
        check("abort_len",   c_len, 100);
        check("abort_busy",  c_busy, 0);

        // Partial trailing byte discarded; old bytes beyond length remain
        send_preamble();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_dibit(2'b10); send_dibit(2'b11);
        end_frame();
        check("partial_len",   c_len, 4);
        check("partial_count", c_cnt, 3);
        check("partial_data",  c_data[31:0], 32'h44332211);
        check("stale_byte4",   c_data[39:32], 8'h04);

        // Hold mode
        do_reset();
        send_preamble();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        end_frame();
        check("holdA_data",  h_data[7:0], 8'hAA);
        check("holdA_count", h_cnt, 1);
        check("holdA_valid", h_valid, 1);
        check("holdA_busy",  h_busy, 0);
        send_preamble();
        send_byte(8'hBB); send_byte(8'h05);
        end_frame();
        check("holdB_frozen", h_data[7:0], 8'hAA);
        check("holdB_count",  h_cnt, 1);
        check("holdB_len",    h_len, 3);
        check("contB_data",   c_data[23:0], 24'h0205BB);
        check("contB_count",  c_cnt, 2);
        check("contB_len",    c_len, 2);
        @(negedge clk); rearm = 1'b1;
        @(negedge clk); rearm = 1'b0;
        check("rearm_valid", h_valid, 0);
        check("rearm_count", h_cnt, 1);
        check("rearm_busy",  h_busy, 0);
        check("rearm_cont_valid", c_valid, 1);
        send_preamble();
        send_byte(8'hBB); send_byte(8'h05);
        end_frame();
        check("holdB2_data",  h_data[15:0], 16'h05BB);
        check("holdB2_count", h_cnt, 2);
        check("holdB2_valid", h_valid, 1);
        check("holdB2_len",   h_len, 2);

        // Raw mode: preamble stored, buffer depth 4
        do_reset();
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hD5);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h06);
        end_frame();
        check("raw_pre",   r_data[15:0], 16'h5555);
        check("raw_data",  r_data, 32'h01D55555);
        check("raw_len",   r_len, 6);
        check("raw_count", r_cnt, 1);

        // Reset mid-DATA
        do_reset();
        send_preamble();
        send_byte(8'h01); send_byte(8'h02);
        send_dibit(2'b01);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("midrst_data",  c_data, '0);
        check("midrst_len",   c_len, 0);
        check("midrst_count", c_cnt, 0);
        check("midrst_valid", c_valid, 0);
        check("midrst_busy",  c_busy, 0);
        reset = 1'b0; crs_dv = 1'b0; rxd = 2'b00;
        @(negedge clk);
        send_preamble();
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        end_frame();
        check("post_count", c_cnt, 1);
        check("post_len",   c_len, 4);
        check("post_data",  c_data[31:0], 32'hD4C3B2A1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
